// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared types for the Wishbone N-master arbiter: policy and FSM state encodings.
package wb_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int MAX_MASTERS = 8;

endpackage

// File: rtl/wishbone_rr_arbiter_picker.sv
// Combinational one-hot picker: rotate requests by ptr, take the lowest set bit, rotate back.
// Fixed mode uses a zero rotation so index 0 always has highest priority.
module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [PTR_W-1:0] sh;
  logic [2*N-1:0]   fwd;
  logic [2*N-1:0]   back;
  logic [N-1:0]     rot;
  logic [N-1:0]     pe;
  logic             hit;

  always_comb begin
    sh   = (mode == ARB_RR) ? ptr : '0;
    fwd  = {req, req} >> sh;
    rot  = fwd[N-1:0];
    pe   = '0;
    hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !hit) begin
        pe[i] = 1'b1;
        hit   = 1'b1;
      end
    end
    back  = {pe, pe} << sh;
    gnt   = back[2*N-1:N];
    valid = |req;
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter with burst-locked grant and ack watchdog.
// Grant registers one cycle after request; one idle cycle separates consecutive bursts.
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int        N_MASTERS = 4,
  parameter int        ADR_W     = 16,
  parameter int        DAT_W     = 8,
  parameter arb_mode_e ARB_MODE  = ARB_RR,
  parameter int        TIMEOUT   = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_cyc,
  input  logic [N_MASTERS-1:0]                m_stb,
  input  logic [N_MASTERS-1:0]                m_we,
  input  logic [N_MASTERS-1:0][ADR_W-1:0]     m_adr,
  input  logic [N_MASTERS-1:0][DAT_W-1:0]     m_dat_w,
  output logic [N_MASTERS-1:0]                m_ack,
  output logic [N_MASTERS-1:0]                m_err,
  output logic [N_MASTERS-1:0]                m_stall,
  output logic [DAT_W-1:0]                    m_dat_r,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADR_W-1:0]                    s_adr,
  output logic [DAT_W-1:0]                    s_dat_w,
  input  logic                                s_ack,
  input  logic                                s_stall,
  input  logic [DAT_W-1:0]                    s_dat_r,
  output logic [N_MASTERS-1:0]                grant
);

  localparam int PTR_W = $clog2(N_MASTERS);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS) begin : g_bad_n
    $error("N_MASTERS out of range");
  end

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [N_MASTERS-1:0]   pick_gnt;
  logic                   pick_vld;
  logic                   g_cyc, g_stb, g_we;
  logic [ADR_W-1:0]       g_adr;
  logic [DAT_W-1:0]       g_dat;
  logic [PTR_W-1:0]       win_idx, next_ptr;
  logic                   busy, timeout_hit;

  rr_priority_picker #(
    .N     (N_MASTERS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (m_cyc),
    .ptr   (rr_ptr_q),
    .mode  (ARB_MODE),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  // AND-OR mux of the granted master; all zeros when nothing is granted.
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_adr   = '0;
    g_dat   = '0;
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      g_cyc = g_cyc | (m_cyc[i] & grant_q[i]);
      g_stb = g_stb | (m_stb[i] & grant_q[i]);
      g_we  = g_we  | (m_we[i]  & grant_q[i]);
      g_adr = g_adr | (m_adr[i]   & {ADR_W{grant_q[i]}});
      g_dat = g_dat | (m_dat_w[i] & {DAT_W{grant_q[i]}});
      if (grant_q[i]) win_idx = PTR_W'(i);
    end
    next_ptr    = (win_idx == PTR_W'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
    busy        = (state_q == BUSY);
    timeout_hit = (TIMEOUT != 0) && (wdog_q == WD_LAST) && !s_ack;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          state_d = BUSY;
          wdog_d  = '0;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          wdog_d  = '0;
          if (ARB_MODE == ARB_RR) rr_ptr_d = next_ptr;
        end else if (s_ack) begin
          wdog_d = '0;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        wdog_d  = '0;
        if (ARB_MODE == ARB_RR) rr_ptr_d = next_ptr;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
    end
  end

  // Gating with rst keeps an in-flight ack/err from leaking out during reset.
  always_comb begin
    s_cyc   = busy;
    s_stb   = busy & g_stb;
    s_we    = g_we;
    s_adr   = g_adr;
    s_dat_w = g_dat;
    m_dat_r = s_dat_r;
    m_ack   = (busy && g_cyc && s_ack && !rst) ? grant_q : '0;
    m_err   = ((state_q == ABORT) && !rst) ? grant_q : '0;
    m_stall = busy ? (~grant_q | {N_MASTERS{s_stall}}) : '1;
    grant   = grant_q;
  end

endmodule
